// File: rtl/rv32i_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_load_store_unit
// Purpose  : RV32I memory-stage load/store unit. Issues one data-memory access
//            at a time, formats store lanes/byte enables, stalls the pipeline
//            while the access is in flight, and returns extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        mem_exc,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  offset_q, offset_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        w_req;
    logic        w_is_write;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [15:0] w_half;
    logic [31:0] w_extended;

    // Request decode and legality check; a write strobe takes precedence.
    always_comb begin
        w_req      = in_valid && (ctrl_mem_read || ctrl_mem_write);
        w_is_write = ctrl_mem_write;
        if (w_is_write) begin
            w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        case (funct3[1:0])
            2'b01:   w_align_ok = (addr[0] == 1'b0);
            2'b10:   w_align_ok = (addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
        w_legal = w_f3_ok && w_align_ok;
    end

    // Store lane formatting: byte enables and lane-replicated write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = 32'h0;
        if (w_is_write) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << addr[1:0];
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // Load extraction uses the offset and funct3 captured at accept time.
    always_comb begin
        w_shifted = mem_rdata >> {offset_q, 3'b000};
        w_half    = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  w_extended = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_extended = {24'h0, w_shifted[7:0]};
            3'b001:  w_extended = {{16{w_half[15]}}, w_half};
            3'b101:  w_extended = {16'h0, w_half};
            default: w_extended = mem_rdata;
        endcase
    end

    // Next-state, registered-output next values and combinational handshakes.
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        load_data_d   = load_data_q;
        offset_d      = offset_q;
        funct3_d      = funct3_q;
        stall         = 1'b0;
        done          = 1'b0;
        mem_exc       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_legal) begin
                        mem_exc = 1'b1;
                        done    = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        state_d       = S_BUSY;
                        mem_address_d = {addr[31:2], 2'b00};
                        mem_read_d    = !w_is_write;
                        mem_write_d   = w_is_write;
                        mem_be_d      = w_be;
                        mem_wdata_d   = w_wdata;
                        offset_d      = addr[1:0];
                        funct3_d      = funct3;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    load_data_d = mem_read_q ? w_extended : 32'h0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_address_q <= 32'h0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
            load_data_q   <= 32'h0;
            offset_q      <= 2'b00;
            funct3_q      <= 3'b000;
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            load_data_q   <= load_data_d;
            offset_q      <= offset_d;
            funct3_q      <= funct3_d;
        end
    end

    assign mem_address     = mem_address_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_wdata       = mem_wdata_q;
    assign load_data       = load_data_q;

endmodule
`default_nettype wire
